// File: rtl/text_console_writer_pkg.sv
// Shared definitions for the text console writer.
// Holds map geometry, field widths, control codes, blank glyph and FSM states.
package text_console_writer_pkg;

    localparam int COLS   = 80;
    localparam int ROWS   = 60;
    localparam int COL_W  = 7;
    localparam int ROW_W  = 6;
    localparam int ADDR_W = ROW_W + COL_W;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    localparam logic [7:0] BLANK_CHAR = 8'h20;

    localparam logic [7:0] CODE_BS = 8'h08;
    localparam logic [7:0] CODE_LF = 8'h0A;
    localparam logic [7:0] CODE_FF = 8'h0C;
    localparam logic [7:0] CODE_CR = 8'h0D;

    typedef enum logic [1:0] {
        IDLE,
        WRITE_WRAP,
        LINE_CLR,
        SCREEN_CLR
    } state_t;

    // Row after the given one, wrapping from the last row to 0.
    function automatic logic [ROW_W-1:0] next_row(
        input logic [ROW_W-1:0] row
    );
        return (row == LAST_ROW) ? '0 : row + 1'b1;
    endfunction

endpackage

// File: rtl/text_console_writer_clear_seq.sv
// console_clear_seq: row/col sweep that emits blank-fill write addresses.
// Ports: clk, rst, start (pulse), screen (1=full map, 0=one line),
// base_row (line to clear), addr/we (write issued this cycle), done (last one).
module console_clear_seq
    import text_console_writer_pkg::*;
#(
    parameter bit START_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              screen,
    input  logic [ROW_W-1:0]  base_row,
    output logic [ADDR_W-1:0] addr,
    output logic              we,
    output logic              done
);

    logic             active;
    logic             mode_screen;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;

    logic             cur_screen;
    logic [ROW_W-1:0] cur_row;
    logic [COL_W-1:0] cur_col;
    logic             last;

    // The start cycle already issues the first address so the owner's
    // registered write port shows it on the very next cycle.
    always_comb begin
        cur_row    = row;
        cur_col    = col;
        cur_screen = mode_screen;
        we         = active;
        if (start) begin
            cur_row    = screen ? '0 : base_row;
            cur_col    = '0;
            cur_screen = screen;
            we         = 1'b1;
        end
        last = (cur_col == LAST_COL) &&
               (!cur_screen || (cur_row == LAST_ROW));
        addr = {cur_row, cur_col};
        done = we && last;
    end

    // row/col always hold the address to issue on the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            active      <= START_ON_RESET;
            mode_screen <= 1'b1;
            row         <= '0;
            col         <= '0;
        end else if (we) begin
            mode_screen <= cur_screen;
            active      <= !last;
            if (cur_col == LAST_COL) begin
                col <= '0;
                row <= cur_row + 1'b1;
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end
        end
    end

endmodule

// File: rtl/text_console_writer.sv
// Byte stream to 80x60 character map writer with cursor and control codes.
// Ports: CLK_50M, RST (sync high), char_data/char_valid/char_ready stream in,
// mem_addr/mem_we/mem_data map write port, cursor_col/cursor_row, busy.
module text_console_writer
    import text_console_writer_pkg::*;
#(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              CLK_50M,
    input  logic              RST,
    input  logic [7:0]        char_data,
    input  logic              char_valid,
    output logic              char_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_data,
    output logic [COL_W-1:0]  cursor_col,
    output logic [ROW_W-1:0]  cursor_row,
    output logic              busy
);

    state_t state;

    logic             accept;
    logic             is_bs;
    logic             is_lf;
    logic             is_ff;
    logic             is_cr;
    logic [ROW_W-1:0] row_inc;
    logic [COL_W-1:0] col_dec;

    logic              seq_start;
    logic              seq_screen;
    logic [ROW_W-1:0]  seq_row;
    logic [ADDR_W-1:0] seq_addr;
    logic              seq_we;
    logic              seq_done;
    logic              done_q;

    assign char_ready = (state == IDLE);
    assign accept     = char_valid && char_ready;

    assign is_bs = (char_data == CODE_BS);
    assign is_lf = (char_data == CODE_LF);
    assign is_ff = (char_data == CODE_FF);
    assign is_cr = (char_data == CODE_CR);

    assign row_inc = next_row(cursor_row);
    assign col_dec = cursor_col - 1'b1;

    // LF/FF start their sweep in the accept cycle; a wrapped printable
    // starts its line clear one cycle later, from WRITE_WRAP, where the
    // cursor already points at the new row.
    assign seq_start  = (accept && (is_lf || is_ff)) ||
                        (state == WRITE_WRAP);
    assign seq_screen = accept && is_ff;
    assign seq_row    = (state == WRITE_WRAP) ? cursor_row : row_inc;

    console_clear_seq #(
        .START_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .clk      (CLK_50M),
        .rst      (RST),
        .start    (seq_start),
        .screen   (seq_screen),
        .base_row (seq_row),
        .addr     (seq_addr),
        .we       (seq_we),
        .done     (seq_done)
    );

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            state      <= CLEAR_ON_RESET ? SCREEN_CLR : IDLE;
            busy       <= CLEAR_ON_RESET;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_data   <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
            done_q     <= 1'b0;
        end else begin
            mem_we <= seq_we;
            done_q <= seq_done;
            if (seq_we) begin
                mem_addr <= seq_addr;
                mem_data <= BLANK_CHAR;
            end
            unique case (state)
                IDLE: begin
                    if (char_valid) begin
                        unique case (1'b1)
                            is_bs: begin
                                if (cursor_col != '0) begin
                                    cursor_col <= col_dec;
                                    mem_we     <= 1'b1;
                                    mem_addr   <= {cursor_row, col_dec};
                                    mem_data   <= BLANK_CHAR;
                                end
                            end
                            is_lf: begin
                                cursor_row <= row_inc;
                                state      <= LINE_CLR;
                                busy       <= 1'b1;
                            end
                            is_ff: begin
                                cursor_row <= '0;
                                cursor_col <= '0;
                                state      <= SCREEN_CLR;
                                busy       <= 1'b1;
                            end
                            is_cr: begin
                                cursor_col <= '0;
                            end
                            default: begin
                                mem_we   <= 1'b1;
                                mem_addr <= {cursor_row, cursor_col};
                                mem_data <= char_data;
                                if (cursor_col == LAST_COL) begin
                                    cursor_col <= '0;
                                    cursor_row <= row_inc;
                                    state      <= WRITE_WRAP;
                                end else begin
                                    cursor_col <= cursor_col + 1'b1;
                                end
                            end
                        endcase
                    end
                end
                WRITE_WRAP: begin
                    state <= LINE_CLR;
                    busy  <= 1'b1;
                end
                default: begin
                    // done_q lines up with the final write on the port.
                    if (done_q) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Testbench for text_console_writer: timeline model of expected port
// activity per cycle, plus directed scenarios with literal expectations.
module tb_text_console_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  char_data;
    logic        char_valid;
    logic        char_ready;
    logic [12:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_data;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #10 clk = ~clk;

    text_console_writer #(.CLEAR_ON_RESET(1'b1)) dut (
        .CLK_50M    (clk),
        .RST        (rst),
        .char_data  (char_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_data   (mem_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    typedef struct {
        logic        we;
        logic [12:0] addr;
        logic [7:0]  data;
        logic        rdy;
        logic        bsy;
        logic [5:0]  row;
        logic [6:0]  col;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [12:0] addr;
        logic [7:0]  data;
    } wr_t;

    exp_t        q[$];
    wr_t         wlog[$];
    exp_t        cur_e;
    int          m_row = 0;
    int          m_col = 0;
    logic [12:0] last_addr = '0;
    logic [7:0]  last_data = '0;
    logic        cur_rdy = 1'b0;
    bit          started = 1'b0;

    function automatic logic [12:0] a(input int r, input int c);
        return 13'(r * 128 + c);
    endfunction

    function automatic void push(input logic we, input logic [12:0] ad,
                                 input logic [7:0] d, input logic rdy,
                                 input logic bsy);
        exp_t e;
        e = '{we: we, addr: ad, data: d, rdy: rdy, bsy: bsy,
              row: 6'(m_row), col: 7'(m_col)};
        q.push_back(e);
    endfunction

    function automatic void push_line(input int r);
        for (int c = 0; c < 80; c++) push(1'b1, a(r, c), 8'h20, 1'b0, 1'b1);
    endfunction

    function automatic void push_screen();
        for (int r = 0; r < 60; r++)
            for (int c = 0; c < 80; c++)
                push(1'b1, a(r, c), 8'h20, 1'b0, 1'b1);
    endfunction

    function automatic void model_reset();
        q.delete();
        m_row = 0;
        m_col = 0;
        last_addr = '0;
        last_data = '0;
        push(1'b0, 13'd0, 8'h00, 1'b0, 1'b1);
        push_screen();
    endfunction

    function automatic void model_accept(input logic [7:0] b);
        int r0;
        case (b)
            8'h08: begin
                if (m_col > 0) begin
                    m_col--;
                    push(1'b1, a(m_row, m_col), 8'h20, 1'b1, 1'b0);
                end
            end
            8'h0A: begin
                m_row = (m_row + 1) % 60;
                push_line(m_row);
            end
            8'h0C: begin
                m_row = 0;
                m_col = 0;
                push_screen();
            end
            8'h0D: m_col = 0;
            default: begin
                if (m_col < 79) begin
                    m_col++;
                    push(1'b1, a(m_row, m_col - 1), b, 1'b1, 1'b0);
                end else begin
                    r0 = m_row;
                    m_col = 0;
                    m_row = (m_row + 1) % 60;
                    push(1'b1, a(r0, 79), b, 1'b0, 1'b0);
                    push_line(m_row);
                end
            end
        endcase
    endfunction

    // Per-cycle compare against the model timeline.
    always @(posedge clk) begin
        if (rst) begin
            model_reset();
            started = 1'b1;
        end else if (started && char_valid && cur_rdy) begin
            model_accept(char_data);
        end
        if (q.size() > 0) begin
            cur_e = q.pop_front();
        end else begin
            cur_e = '{we: 1'b0, addr: last_addr, data: last_data,
                      rdy: 1'b1, bsy: 1'b0,
                      row: 6'(m_row), col: 7'(m_col)};
        end
        if (cur_e.we) begin
            last_addr = cur_e.addr;
            last_data = cur_e.data;
        end
        cur_rdy = cur_e.rdy;
        cyc++;
        #1;
        if (started) begin
            n_cmp++;
            if (mem_we !== cur_e.we || mem_addr !== cur_e.addr ||
                mem_data !== cur_e.data || char_ready !== cur_e.rdy ||
                busy !== cur_e.bsy || cursor_row !== cur_e.row ||
                cursor_col !== cur_e.col) begin
                n_bad++;
                $display("FAIL cycle %0d: got we=%b addr=%0d data=%h rdy=%b busy=%b cur=(%0d,%0d) want we=%b addr=%0d data=%h rdy=%b busy=%b cur=(%0d,%0d)",
                         cyc, mem_we, mem_addr, mem_data, char_ready, busy,
                         cursor_row, cursor_col, cur_e.we, cur_e.addr,
                         cur_e.data, cur_e.rdy, cur_e.bsy, cur_e.row,
                         cur_e.col);
            end
            if (mem_we) wlog.push_back('{cyc: cyc, addr: mem_addr, data: mem_data});
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_cursor(input string name, input int r, input int c);
        check({name, " row"}, 32'(cursor_row), 32'(r));
        check({name, " col"}, 32'(cursor_col), 32'(c));
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        char_data  = b;
        char_valid = 1'b1;
        while (!char_ready && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (!char_ready) begin
            check("send timeout", 32'(char_ready), 32'd1);
        end
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int limit);
        int n;
        n = 0;
        while (!char_ready && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({name, " ready"}, 32'(char_ready), 32'd1);
    endtask

    task automatic check_full_sweep(input string name);
        int bad;
        bad = 0;
        check({name, " count"}, 32'(wlog.size()), 32'd4800);
        if (wlog.size() == 4800) begin
            for (int i = 0; i < 4800; i++) begin
                if (wlog[i].addr !== a(i / 80, i % 80) ||
                    wlog[i].data !== 8'h20 ||
                    wlog[i].cyc != wlog[0].cyc + i)
                    bad++;
            end
            check({name, " first addr"}, 32'(wlog[0].addr), 32'd0);
            check({name, " last addr"}, 32'(wlog[4799].addr), 32'd7631);
        end
        check({name, " seq errors"}, 32'(bad), 32'd0);
    endtask

    initial begin
        logic [7:0] pat [5];
        int bad;
        pat = '{8'h00, 8'hFF, 8'h80, 8'h7F, 8'h41};
        rst        = 1'b1;
        char_valid = 1'b0;
        char_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset ready", 32'(char_ready), 32'd0);
        check("reset busy", 32'(busy), 32'd1);
        check_cursor("reset cursor", 0, 0);
        wait_ready("init", 6000);
        check_full_sweep("init sweep");
        check_cursor("init cursor", 0, 0);

        wlog.delete();
        send(8'h41);
        send(8'h42);
        check("AB count", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            check("A addr", 32'(wlog[0].addr), 32'd0);
            check("A data", 32'(wlog[0].data), 32'h41);
            check("B addr", 32'(wlog[1].addr), 32'd1);
            check("B data", 32'(wlog[1].data), 32'h42);
            check("AB back-to-back", 32'(wlog[1].cyc - wlog[0].cyc), 32'd1);
        end
        check_cursor("AB cursor", 0, 2);

        send(8'h0D);
        wlog.delete();
        for (int i = 0; i < 80; i++) send(8'(8'h41 + (i % 26)));
        check("wrap ready low", 32'(char_ready), 32'd0);
        wait_ready("wrap", 200);
        check("wrap count", 32'(wlog.size()), 32'd160);
        if (wlog.size() == 160) begin
            bad = 0;
            for (int i = 80; i < 160; i++)
                if (wlog[i].addr !== a(1, i - 80) || wlog[i].data !== 8'h20)
                    bad++;
            check("wrap 80th addr", 32'(wlog[79].addr), 32'd79);
            check("wrap clr first", 32'(wlog[80].addr), 32'd128);
            check("wrap clr last", 32'(wlog[159].addr), 32'd207);
            check("wrap clr gap", 32'(wlog[80].cyc - wlog[79].cyc), 32'd1);
            check("wrap clr span", 32'(wlog[159].cyc - wlog[80].cyc), 32'd79);
            check("wrap clr errors", 32'(bad), 32'd0);
        end
        check_cursor("wrap cursor", 1, 0);

        for (int i = 0; i < 58; i++) begin
            send(8'h0A);
            wait_ready("lf walk", 200);
        end
        for (int i = 0; i < 10; i++) send(8'(8'h61 + i));
        check_cursor("row59 cursor", 59, 10);
        wlog.delete();
        send(8'h0A);
        check_cursor("lf wrap cursor", 0, 10);
        wait_ready("lf wrap", 200);
        check("lf clr count", 32'(wlog.size()), 32'd80);
        if (wlog.size() == 80) begin
            check("lf clr first", 32'(wlog[0].addr), 32'd0);
            check("lf clr last", 32'(wlog[79].addr), 32'd79);
        end
        wlog.delete();
        send(8'h0D);
        @(negedge clk);
        check("cr no write", 32'(wlog.size()), 32'd0);
        check_cursor("cr cursor", 0, 0);

        for (int i = 0; i < 3; i++) begin
            send(8'h0A);
            wait_ready("lf to 3", 200);
        end
        wlog.delete();
        for (int i = 0; i < 5; i++) send(pat[i]);
        check_cursor("row3 cursor", 3, 5);
        if (wlog.size() == 5) begin
            check("byte 00 addr", 32'(wlog[0].addr), 32'd384);
            check("byte 00 data", 32'(wlog[0].data), 32'h00);
            check("byte FF data", 32'(wlog[1].data), 32'hFF);
        end else begin
            check("hi byte count", 32'(wlog.size()), 32'd5);
        end
        wlog.delete();
        send(8'h08);
        check("bs count", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) begin
            check("bs addr", 32'(wlog[0].addr), 32'd388);
            check("bs data", 32'(wlog[0].data), 32'h20);
        end
        check_cursor("bs cursor", 3, 4);
        wlog.delete();
        repeat (5) send(8'h08);
        @(negedge clk);
        check("bs5 count", 32'(wlog.size()), 32'd4);
        if (wlog.size() == 4)
            check("bs5 last addr", 32'(wlog[3].addr), 32'd384);
        check_cursor("bs5 cursor", 3, 0);

        for (int i = 0; i < 17; i++) begin
            send(8'h0A);
            wait_ready("lf to 20", 200);
        end
        for (int i = 0; i < 40; i++) send(8'(8'h30 + (i % 10)));
        check_cursor("row20 cursor", 20, 40);
        send(8'h0C);
        repeat (100) @(negedge clk);
        check("ff busy", 32'(busy), 32'd1);
        wlog.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort mem_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_cursor("abort cursor", 0, 0);
        wait_ready("abort", 6000);
        check_full_sweep("abort sweep");
        check_cursor("abort end cursor", 0, 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
